// File: rtl/bvb_pkg.sv
// ============================================================================
// Module   : bvb_pkg
// Brief    : Port indices, arbitration order and address-decode helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bvb_pkg;

  typedef enum logic [1:0] {
    PORT_WB  = 2'd0,
    PORT_ACT = 2'd1,
    PORT_WGT = 2'd2,
    PORT_DMA = 2'd3
  } port_e;

  localparam int NUM_PORTS = 4;

  // Highest priority first; used only when urgency does not decide.
  localparam port_e PRIO_ORDER [NUM_PORTS] = '{PORT_WB, PORT_ACT, PORT_WGT, PORT_DMA};

  function automatic int prio_rank(input port_e p);
    int r;
    r = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PRIO_ORDER[i] == p) r = i;
    end
    return r;
  endfunction

  function automatic int unsigned addr_bank(input int unsigned addr, input int bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic int unsigned addr_row(input int unsigned addr, input int bank_bits);
    return addr >> bank_bits;
  endfunction

  function automatic int unsigned addr_group(input int unsigned addr, input int bank_bits,
                                             input int lane_bits);
    return addr_bank(addr, bank_bits) >> lane_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bvb_bank_group.sv
// ============================================================================
// Module   : bvb_bank_group
// Brief    : LANES single-port banks sharing one row, per-lane write mask,
//            registered read data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bvb_bank_group
  import bvb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int BANK_DEPTH = 4096,
  localparam int ROW_W     = $clog2(BANK_DEPTH),
  localparam int VEC_W     = LANES * DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             i_acc,
  input  logic             i_we,
  input  logic [ROW_W-1:0] i_row,
  input  logic [VEC_W-1:0] i_wdata,
  input  logic [LANES-1:0] i_mask,
  output logic [VEC_W-1:0] o_rdata
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;

    always_ff @(posedge CLK) begin
      if (i_acc) begin
        if (i_we) begin
          if (i_mask[l]) r_mem[i_row] <= i_wdata[l*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          r_rd <= r_mem[i_row];
        end
      end
    end

    assign o_rdata[l*DATA_WIDTH +: DATA_WIDTH] = r_rd;
  end

endmodule

`default_nettype wire

// File: rtl/banked_vector_buffer.sv
// ============================================================================
// Module   : banked_vector_buffer
// Brief    : Banked vector buffer, two read and two write ports, per-group
//            fixed-priority arbitration with starvation aging.
// Revision : 1.0
// ============================================================================
`default_nettype none

module banked_vector_buffer
  import bvb_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_BANKS    = 16,
  parameter int BANK_DEPTH   = 4096,
  parameter int LANES        = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int GROUPS      = NUM_BANKS / LANES,
  localparam int ADDR_WIDTH  = $clog2(NUM_BANKS) + $clog2(BANK_DEPTH),
  localparam int VEC_W       = LANES * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic                  ActRdValid,
  output logic                  ActRdReady,
  input  logic [ADDR_WIDTH-1:0] ActRdAddr,
  output logic                  ActRspValid,
  output logic [VEC_W-1:0]      ActRspData,
  input  logic                  WgtRdValid,
  output logic                  WgtRdReady,
  input  logic [ADDR_WIDTH-1:0] WgtRdAddr,
  output logic                  WgtRspValid,
  output logic [VEC_W-1:0]      WgtRspData,
  input  logic                  DmaWrValid,
  output logic                  DmaWrReady,
  input  logic [ADDR_WIDTH-1:0] DmaWrAddr,
  input  logic [VEC_W-1:0]      DmaWrData,
  input  logic [LANES-1:0]      DmaWrMask,
  input  logic                  WbWrValid,
  output logic                  WbWrReady,
  input  logic [ADDR_WIDTH-1:0] WbWrAddr,
  input  logic [VEC_W-1:0]      WbWrData,
  input  logic [LANES-1:0]      WbWrMask
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LANE_BITS = $clog2(LANES);
  localparam int ROW_W     = $clog2(BANK_DEPTH);
  localparam int GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam int NUM_RD    = 2;
  localparam port_e RD_PORT [NUM_RD] = '{PORT_ACT, PORT_WGT};

  logic [NUM_PORTS-1:0]  w_valid, w_win, w_ready, w_xfer, w_urg;
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [VEC_W-1:0]      w_wdata [NUM_PORTS];
  logic [LANES-1:0]      w_wmask [NUM_PORTS];
  logic [GRP_W-1:0]      w_grp   [NUM_PORTS];
  logic [ROW_W-1:0]      w_row   [NUM_PORTS];
  logic [CNT_W-1:0]      r_cnt   [NUM_PORTS];
  logic [VEC_W-1:0]      w_g_rd  [GROUPS];

  logic [NUM_RD-1:0]     r_pend;
  logic [GRP_W-1:0]      r_pgrp      [NUM_RD];
  logic                  r_rsp_valid [NUM_RD];
  logic [VEC_W-1:0]      r_rsp_data  [NUM_RD];

  assign w_valid[PORT_WB]  = WbWrValid;
  assign w_valid[PORT_ACT] = ActRdValid;
  assign w_valid[PORT_WGT] = WgtRdValid;
  assign w_valid[PORT_DMA] = DmaWrValid;
  assign w_addr[PORT_WB]   = WbWrAddr;
  assign w_addr[PORT_ACT]  = ActRdAddr;
  assign w_addr[PORT_WGT]  = WgtRdAddr;
  assign w_addr[PORT_DMA]  = DmaWrAddr;
  assign w_wdata[PORT_WB]  = WbWrData;
  assign w_wdata[PORT_ACT] = '0;
  assign w_wdata[PORT_WGT] = '0;
  assign w_wdata[PORT_DMA] = DmaWrData;
  assign w_wmask[PORT_WB]  = WbWrMask;
  assign w_wmask[PORT_ACT] = '0;
  assign w_wmask[PORT_WGT] = '0;
  assign w_wmask[PORT_DMA] = DmaWrMask;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_grp[p] = GRP_W'(addr_group(32'(w_addr[p]), BANK_BITS, LANE_BITS));
    assign w_row[p] = ROW_W'(addr_row(32'(w_addr[p]), BANK_BITS));
    assign w_urg[p] = (r_cnt[p] == CNT_W'(STARVE_LIMIT));
  end

  // A requester loses if any other requester to the same group outranks it.
  always_comb begin
    w_win = w_valid;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && w_valid[q] && w_grp[q] == w_grp[p] &&
            ((w_urg[q] && !w_urg[p]) ||
             (w_urg[q] == w_urg[p] &&
              prio_rank(port_e'(q[1:0])) < prio_rank(port_e'(p[1:0])))))
          w_win[p] = 1'b0;
      end
    end
  end

  assign w_ready = (EN && !SYNC_RST) ? w_win : '0;
  assign w_xfer  = w_valid & w_ready;

  assign WbWrReady  = w_ready[PORT_WB];
  assign ActRdReady = w_ready[PORT_ACT];
  assign WgtRdReady = w_ready[PORT_WGT];
  assign DmaWrReady = w_ready[PORT_DMA];

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
    end else if (EN) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!w_valid[p] || w_ready[p]) r_cnt[p] <= '0;
        else if (!w_urg[p])            r_cnt[p] <= r_cnt[p] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic             w_acc, w_we;
    logic [ROW_W-1:0] w_grow;
    logic [VEC_W-1:0] w_gwdata;
    logic [LANES-1:0] w_gmask;

    // At most one port per group is granted, so this is a one-hot select.
    always_comb begin
      w_acc    = 1'b0;
      w_we     = 1'b0;
      w_grow   = '0;
      w_gwdata = '0;
      w_gmask  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_xfer[p] && w_grp[p] == GRP_W'(g)) begin
          w_acc  = 1'b1;
          w_grow = w_row[p];
          if (p == int'(PORT_WB) || p == int'(PORT_DMA)) begin
            w_we     = 1'b1;
            w_gwdata = w_wdata[p];
            w_gmask  = w_wmask[p];
          end
        end
      end
    end

    bvb_bank_group #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .BANK_DEPTH (BANK_DEPTH)
    ) u_bank_group (
      .CLK     (CLK),
      .i_acc   (w_acc),
      .i_we    (w_we),
      .i_row   (w_grow),
      .i_wdata (w_gwdata),
      .i_mask  (w_gmask),
      .o_rdata (w_g_rd[g])
    );
  end

  // Bank data lands one edge after the handshake; the response register
  // takes it on the following enabled edge, so a reset there drops it.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      r_pend <= '0;
      for (int k = 0; k < NUM_RD; k++) begin
        r_pgrp[k]      <= '0;
        r_rsp_valid[k] <= 1'b0;
        r_rsp_data[k]  <= '0;
      end
    end else if (EN) begin
      for (int k = 0; k < NUM_RD; k++) begin
        r_pend[k]      <= w_xfer[RD_PORT[k]];
        r_pgrp[k]      <= w_grp[RD_PORT[k]];
        r_rsp_valid[k] <= r_pend[k];
        if (r_pend[k]) r_rsp_data[k] <= w_g_rd[r_pgrp[k]];
      end
    end
  end

  assign ActRspValid = r_rsp_valid[0];
  assign ActRspData  = r_rsp_data[0];
  assign WgtRspValid = r_rsp_valid[1];
  assign WgtRspData  = r_rsp_data[1];

endmodule

`default_nettype wire
